// File: rtl/parity_pkg.sv
// Shared types and the parity reduction used by the parity generator/checker.
package parity_pkg;

  typedef enum logic [1:0] {
    NOPARITY00 = 2'b00,
    ODD        = 2'b01,
    EVEN       = 2'b10,
    NOPARITY11 = 2'b11
  } parity_type_t;

  typedef enum logic {
    GEN   = 1'b0,
    CHECK = 1'b1
  } mode_t;

  localparam int unsigned MAX_DATA_W = 64;

  // Zero-extension is harmless: extra zero bits do not change an XOR reduction.
  function automatic logic parity_of(input logic [MAX_DATA_W-1:0] data,
                                     input parity_type_t ptype);
    logic p;
    case (ptype)
      ODD:     p = ~^data;
      EVEN:    p = ^data;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity bit and mismatch flag for one DATA_W-bit word.
module parity_calc
  import parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        ptype_i,
  input  logic              mode_i,
  input  logic              parity_in_i,
  output logic              parity_o,
  output logic              err_o
);

  logic [MAX_DATA_W-1:0] wide;
  parity_type_t          ptype;
  logic                  is_typed;

  always_comb begin
    wide = '0;
    wide[DATA_W-1:0] = data_i;
  end

  assign ptype    = parity_type_t'(ptype_i);
  assign is_typed = (ptype == ODD) || (ptype == EVEN);
  assign parity_o = parity_of(wide, ptype);
  assign err_o    = (mode_t'(mode_i) == CHECK) && is_typed && (parity_in_i != parity_o);

endmodule

// File: rtl/parity_gen_check.sv
// One-stage valid/ready parity generator/checker with sticky error flag.
// Define PARITY_ERR_CNT_EN to add the saturating CNT_W-bit err_count output.
module parity_gen_check
  import parity_pkg::*;
#(
  parameter int DATA_W = 8
`ifdef PARITY_ERR_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [1:0]        parity_type,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity,
  output logic              out_err,
  input  logic              err_clr,
  output logic              err_sticky
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_count
`endif
);

  logic              calc_parity, calc_err;
  logic              accept, err_hit;
  logic              vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0] data_p1_q, data_p1_d;
  logic              par_p1_q, par_p1_d;
  logic              err_p1_q, err_p1_d;
  logic              sticky_q, sticky_d;

  parity_calc #(.DATA_W(DATA_W)) u_calc (
    .data_i      (in_data),
    .ptype_i     (parity_type),
    .mode_i      (mode),
    .parity_in_i (in_parity),
    .parity_o    (calc_parity),
    .err_o       (calc_err)
  );

  // Stage p0 -> p1: only out_ready reaches in_ready combinationally.
  assign in_ready = !reset && (!vld_p1_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign err_hit  = accept && calc_err;

  always_comb begin
    vld_p1_d  = vld_p1_q;
    data_p1_d = data_p1_q;
    par_p1_d  = par_p1_q;
    err_p1_d  = err_p1_q;
    sticky_d  = sticky_q;
    if (accept) begin
      vld_p1_d  = 1'b1;
      data_p1_d = in_data;
      par_p1_d  = calc_parity;
      err_p1_d  = calc_err;
    end else if (out_ready) begin
      vld_p1_d  = 1'b0;
    end
    // A new error outranks a simultaneous clear.
    if (err_hit)      sticky_d = 1'b1;
    else if (err_clr) sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
      par_p1_q  <= 1'b0;
      err_p1_q  <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      data_p1_q <= data_p1_d;
      par_p1_q  <= par_p1_d;
      err_p1_q  <= err_p1_d;
      sticky_q  <= sticky_d;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (err_hit) begin
      if (err_clr)        cnt_d = CNT_W'(1);
      else if (~&cnt_q)   cnt_d = cnt_q + CNT_W'(1);
    end else if (err_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`endif

  assign out_valid  = vld_p1_q;
  assign out_data   = data_p1_q;
  assign out_parity = par_p1_q;
  assign out_err    = err_p1_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_parity_gen_check.sv
// Directed bench for parity_gen_check; err_count checks follow PARITY_ERR_CNT_EN.
module tb_parity_gen_check;

  logic       clk = 1'b0;
  logic       reset, mode, in_valid, in_parity, out_ready, err_clr;
  logic [1:0] parity_type;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_parity, out_err, err_sticky;
  logic [7:0] out_data;
`ifdef PARITY_ERR_CNT_EN
  logic [1:0] err_count;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  parity_gen_check #(
    .DATA_W(8)
`ifdef PARITY_ERR_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .parity_type (parity_type),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_parity   (in_parity),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_parity  (out_parity),
    .out_err     (out_err),
    .err_clr     (err_clr),
    .err_sticky  (err_sticky)
`ifdef PARITY_ERR_CNT_EN
    , .err_count (err_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] gen_type [4];
  logic       gen_par  [4];

  initial begin
    gen_type = '{2'b10, 2'b01, 2'b00, 2'b11};
    gen_par  = '{1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_parity = 1'b0;
    out_ready = 1'b1; err_clr = 1'b0; parity_type = 2'b00; in_data = 8'h00;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0; #1;
    check("post_rst_in_ready", in_ready, 1);

    // Generate mode, back-to-back, all four parity types
    mode = 1'b0; in_valid = 1'b1; in_data = 8'b00010111;
    for (int i = 0; i < 4; i++) begin
      parity_type = gen_type[i];
      if (i == 0) begin
        #1;
        check("gen_latency_pre", out_valid, 0);
      end
      step();
      check($sformatf("gen_valid_%0d", i), out_valid, 1);
      check($sformatf("gen_parity_%0d", i), out_parity, gen_par[i]);
      check($sformatf("gen_err_%0d", i), out_err, 0);
      check($sformatf("gen_data_%0d", i), out_data, 8'h17);
    end
    in_valid = 1'b0;
    step();
    check("gen_drain", out_valid, 0);

    // Check mode, EVEN, three ones
    mode = 1'b1; parity_type = 2'b10; in_data = 8'b00000111; in_parity = 1'b0;
    in_valid = 1'b1;
    step();
    check("chk_err", out_err, 1);
    check("chk_parity", out_parity, 1);
    check("chk_sticky", err_sticky, 1);
`ifdef PARITY_ERR_CNT_EN
    check("chk_count", err_count, 1);
`endif
    in_parity = 1'b1;
    step();
    check("chk_ok_err", out_err, 0);
    check("chk_ok_sticky", err_sticky, 1);
`ifdef PARITY_ERR_CNT_EN
    check("chk_ok_count", err_count, 1);
`endif
    in_valid = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("chk_clr_sticky", err_sticky, 0);

    // Backpressure
    mode = 1'b0; parity_type = 2'b10; in_valid = 1'b1; in_data = 8'h11;
    step();
    check("bp_first", out_data, 8'h11);
    out_ready = 1'b0; in_data = 8'h22; #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_ready_%0d", i), in_ready, 0);
      step();
      check($sformatf("bp_hold_%0d", i), out_data, 8'h11);
      check($sformatf("bp_valid_%0d", i), out_valid, 1);
    end
    out_ready = 1'b1; #1;
    check("bp_resume_ready", in_ready, 1);
    step();
    check("bp_word2", out_data, 8'h22);
    in_data = 8'h33;
    step();
    check("bp_word3", out_data, 8'h33);
    check("bp_word3_parity", out_parity, 0);
    in_valid = 1'b0;
    step();
    check("bp_drain", out_valid, 0);

    // Saturation and clear priority
    mode = 1'b1; parity_type = 2'b10; in_data = 8'h07; in_parity = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    check("sat_sticky", err_sticky, 1);
`ifdef PARITY_ERR_CNT_EN
    check("sat_count", err_count, 3);
`endif
    err_clr = 1'b1;
    step();
    check("clr_sticky", err_sticky, 0);
`ifdef PARITY_ERR_CNT_EN
    check("clr_count", err_count, 0);
`endif
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    check("clr_err_sticky", err_sticky, 1);
`ifdef PARITY_ERR_CNT_EN
    check("clr_err_count", err_count, 1);
`endif
    step();

    // Reset during a stalled erroring word
    in_valid = 1'b1; in_data = 8'h07; in_parity = 1'b0;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    check("stall_valid", out_valid, 1);
    check("stall_err", out_err, 1);
    reset = 1'b1;
    step();
    check("mrst_valid", out_valid, 0);
    check("mrst_data", out_data, 0);
    check("mrst_parity", out_parity, 0);
    check("mrst_err", out_err, 0);
    check("mrst_sticky", err_sticky, 0);
`ifdef PARITY_ERR_CNT_EN
    check("mrst_count", err_count, 0);
`endif
    check("mrst_in_ready", in_ready, 0);
    reset = 1'b0; #1;
    check("mrst_release_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
